basys3_seg_mux: RTL and testbench



---
 rtl/seg_pkg.sv | 40 ++++
 rtl/basys3_seg_mux_if.sv | 26 ++
 rtl/hex7seg.sv | 12 +
 rtl/basys3_seg_mux.sv | 144 ++++++++++++++
 tb/tb_basys3_seg_mux.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types, constants and the hex glyph table for the seven-segment scan driver.
package seg_pkg;

    // Segment vector, bit 0 = segment a ... bit 6 = segment g
    typedef logic [6:0] seg7_t;

    localparam seg7_t      SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Scan sequencer states
    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } scan_state_t;

    // Active-high glyph for one hex nibble; b and d are lower case, 6 and 9 carry tails
    function automatic seg7_t hex_to_seg(input logic [3:0] nib);
        seg7_t g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/basys3_seg_mux_if.sv
// Host-side bus of the display driver: value/decimal-point capture plus display controls.
interface basys3_seg_mux_if;
    logic        enable;
    logic        update;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        blank_lz;

    // The user project drives the bus
    modport master (
        output enable,
        output update,
        output value_in,
        output dp_in,
        output blank_lz
    );

    // The display driver consumes it
    modport slave (
        input enable,
        input update,
        input value_in,
        input dp_in,
        input blank_lz
    );
endinterface

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg_n
);

    // Pins are active-low, the table is active-high
    assign seg_n = ~hex_to_seg(nibble);

endmodule

// File: rtl/basys3_seg_mux.sv
// Four-digit multiplexed seven-segment driver with inter-digit dead-time,
// frame-aligned (tear-free) value updates and optional leading-zero blanking.
module basys3_seg_mux
    import seg_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int GAP_CYC  = 200
) (
    input  logic                   clock,
    input  logic                   reset,
    basys3_seg_mux_if.slave        host,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [3:0]             an
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);

    scan_state_t   state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic [15:0]   disp_val_q, disp_val_d;
    logic [3:0]    disp_dp_q, disp_dp_d;
    seg7_t         seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic          frame_end;
    logic [3:0]    nibble;
    seg7_t         glyph_n;
    logic          zero3, zero2, zero1;
    logic          blank;
    logic          lit;

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg_n  (glyph_n)
    );

    // Scan sequencing and value capture; display regs only move at the frame boundary
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        presc_d    = presc_q;
        gap_d      = gap_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        frame_end  = 1'b0;

        case (state_q)
            ST_SHOW: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    state_d = ST_GAP;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d     = '0;
                    idx_d     = idx_q + 2'd1;
                    state_d   = ST_SHOW;
                    frame_end = (idx_q == 2'd3);
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
        endcase

        if (host.update) begin
            pend_val_d = host.value_in;
            pend_dp_d  = host.dp_in;
        end

        // Using the next pending value lets a boundary-cycle update land in this frame
        if (frame_end) begin
            disp_val_d = pend_val_d;
            disp_dp_d  = pend_dp_d;
        end
    end

    // Digit decode, leading-zero blanking and next pin values
    always_comb begin
        nibble = disp_val_q[{idx_q, 2'b00} +: 4];
        zero3  = (disp_val_q[15:12] == 4'h0);
        zero2  = zero3 && (disp_val_q[11:8] == 4'h0);
        zero1  = zero2 && (disp_val_q[7:4] == 4'h0);

        case (idx_q)
            2'd3:    blank = host.blank_lz && zero3;
            2'd2:    blank = host.blank_lz && zero2;
            2'd1:    blank = host.blank_lz && zero1;
            default: blank = 1'b0;
        endcase

        lit  = (state_q == ST_SHOW) && host.enable && !blank;
        an_d = lit ? ~(4'b0001 << idx_q) : AN_OFF;
        seg_d = lit ? glyph_n : SEG_OFF;
        dp_d  = lit ? ~disp_dp_q[idx_q] : 1'b1;
    end

    // State, capture and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_SHOW;
            idx_q      <= 2'd0;
            presc_q    <= '0;
            gap_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
            an_q       <= AN_OFF;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            presc_q    <= presc_d;
            gap_q      <= gap_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_basys3_seg_mux.sv
// Bench for basys3_seg_mux with a short scan (4 lit cycles, 1 gap cycle per digit).
module tb_basys3_seg_mux;

    localparam int TICK  = 4;
    localparam int GAP   = 1;
    localparam int PER   = TICK + GAP;
    localparam int FRAME = 4 * PER;

    // Active-low glyphs, written out directly from the segment drawings
    localparam logic [6:0] GLYPH_N [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    basys3_seg_mux_if bus ();

    basys3_seg_mux #(.TICK_DIV(TICK), .GAP_CYC(GAP)) dut (
        .clock (clock),
        .reset (reset),
        .host  (bus),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Scan-position model: time since reset decides digit and lit/gap slot
    int          m_t = 0;
    logic        m_valid = 1'b0;
    logic [15:0] m_pend_v, m_disp_v;
    logic [3:0]  m_pend_dp, m_disp_dp;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;

    always @(posedge clock) begin : model
        int          pos, d, w;
        logic        blank, lit;
        logic [3:0]  an_pat;
        logic [3:0]  nib;
        logic [15:0] nxt_v;
        logic [3:0]  nxt_dp;
        if (reset) begin
            m_t       <= 0;
            m_pend_v  <= '0;
            m_pend_dp <= '0;
            m_disp_v  <= '0;
            m_disp_dp <= '0;
            exp_an    <= 4'hF;
            exp_seg   <= 7'h7F;
            exp_dp    <= 1'b1;
            m_valid   <= 1'b1;
        end else begin
            pos    = m_t % FRAME;
            d      = pos / PER;
            w      = pos % PER;
            blank  = bus.blank_lz && (d > 0) && ((m_disp_v >> (4 * d)) == 16'd0);
            lit    = (w < TICK) && bus.enable && !blank;
            nib    = m_disp_v[4*d +: 4];
            an_pat = 4'b1111;
            an_pat[d] = 1'b0;
            exp_an  <= lit ? an_pat : 4'hF;
            exp_seg <= lit ? GLYPH_N[nib] : 7'h7F;
            exp_dp  <= lit ? ~m_disp_dp[d] : 1'b1;
            nxt_v  = bus.update ? bus.value_in : m_pend_v;
            nxt_dp = bus.update ? bus.dp_in : m_pend_dp;
            m_pend_v  <= nxt_v;
            m_pend_dp <= nxt_dp;
            if (pos == FRAME - 1) begin
                m_disp_v  <= nxt_v;
                m_disp_dp <= nxt_dp;
            end
            m_t <= (m_t + 1) % FRAME;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (m_valid) begin
            n_checks++;
            if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t an=%b req=%b seg=%h req=%h dp=%b req=%b",
                         $time, an, exp_an, seg, exp_seg, dp, exp_dp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_an(input logic [3:0] pat, input string name);
        int n;
        n = 0;
        while (an !== pat && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_reached"}, 32'(n < 200), 32'd1);
    endtask

    task automatic pulse_update(input logic [15:0] v, input logic [3:0] d);
        bus.update   = 1'b1;
        bus.value_in = v;
        bus.dp_in    = d;
        @(negedge clock);
        bus.update   = 1'b0;
    endtask

    initial begin
        logic bad;
        int   n;
        reset        = 1'b1;
        bus.enable   = 1'b1;
        bus.update   = 1'b0;
        bus.value_in = '0;
        bus.dp_in    = '0;
        bus.blank_lz = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_an", 32'(an), 32'h0000000F);
        chk("rst_seg", 32'(seg), 32'h0000007F);
        chk("rst_dp", 32'(dp), 32'd1);
        @(negedge clock);
        reset = 1'b0;

        // Basic scan, all digits show 0
        @(negedge clock);
        chk("t1_first_an", 32'(an), 32'h0000000E);
        chk("t1_first_seg", 32'(seg), 32'h00000040);
        chk("t1_first_dp", 32'(dp), 32'd1);
        repeat (24) @(negedge clock);

        // Mid-frame update is held until the next frame
        wait_an(4'b1101, "t2_d1");
        pulse_update(16'h12AF, 4'b0100);
        wait_an(4'b1011, "t2_old_d2");
        chk("t2_old_d2_seg", 32'(seg), 32'h00000040);
        wait_an(4'b1110, "t2_d0");
        chk("t2_d0_seg", 32'(seg), 32'h0000000E);
        chk("t2_d0_model", 32'(exp_seg), 32'h0000000E);
        chk("t2_d0_dp", 32'(dp), 32'd1);
        wait_an(4'b1101, "t2_d1b");
        chk("t2_d1_seg", 32'(seg), 32'h00000008);
        wait_an(4'b1011, "t2_d2");
        chk("t2_d2_seg", 32'(seg), 32'h00000024);
        chk("t2_d2_dp", 32'(dp), 32'd0);
        wait_an(4'b0111, "t2_d3");
        chk("t2_d3_seg", 32'(seg), 32'h00000079);
        chk("t2_d3_dp", 32'(dp), 32'd1);

        // Leading-zero blanking
        bus.blank_lz = 1'b1;
        pulse_update(16'h0070, 4'b0000);
        repeat (25) @(negedge clock);
        bad = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (an[3] == 1'b0 || an[2] == 1'b0) bad = 1'b1;
            @(negedge clock);
        end
        chk("t3_upper_dark", 32'(bad), 32'd0);
        wait_an(4'b1101, "t3_d1");
        chk("t3_d1_seg", 32'(seg), 32'h00000078);
        wait_an(4'b1110, "t3_d0");
        chk("t3_d0_seg", 32'(seg), 32'h00000040);
        pulse_update(16'h0000, 4'b0000);
        repeat (25) @(negedge clock);
        bad = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (an !== 4'b1110 && an !== 4'b1111) bad = 1'b1;
            @(negedge clock);
        end
        chk("t3_only_d0", 32'(bad), 32'd0);

        // Update on the exact frame-boundary cycle
        bus.blank_lz = 1'b0;
        n = 0;
        while (m_t != FRAME - 1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("t4_boundary_reached", 32'(n < 100), 32'd1);
        pulse_update(16'hBEEF, 4'b0000);
        wait_an(4'b1110, "t4_d0");
        chk("t4_d0_seg", 32'(seg), 32'h0000000E);
        wait_an(4'b1101, "t4_d1");
        chk("t4_d1_seg", 32'(seg), 32'h00000006);
        wait_an(4'b1011, "t4_d2");
        chk("t4_d2_seg", 32'(seg), 32'h00000006);
        wait_an(4'b0111, "t4_d3");
        chk("t4_d3_seg", 32'(seg), 32'h00000003);

        // Display disabled mid-digit2, scan keeps running
        wait_an(4'b1011, "t5_d2");
        bus.enable = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) bad = 1'b1;
        end
        chk("t5_dark", 32'(bad), 32'd0);
        bus.enable = 1'b1;
        repeat (2 * FRAME) @(negedge clock);

        // Reset mid-scan discards displayed and pending values
        pulse_update(16'h5555, 4'b0000);
        repeat (25) @(negedge clock);
        wait_an(4'b0111, "t6_d3");
        chk("t6_d3_seg", 32'(seg), 32'h00000012);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_rst_an", 32'(an), 32'h0000000F);
        chk("t6_rst_seg", 32'(seg), 32'h0000007F);
        chk("t6_rst_dp", 32'(dp), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        wait_an(4'b1110, "t6_d0");
        chk("t6_d0_seg", 32'(seg), 32'h00000040);
        wait_an(4'b0111, "t6_d3b");
        chk("t6_d3b_seg", 32'(seg), 32'h00000040);
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
